// File: rtl/pending_encoder8.sv
// Registered 8-to-3 priority encoder. Request strobes are captured in a sticky
// pending register; the highest pending index is presented until acknowledged.
module pending_encoder8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending
);

  logic [7:0] pend_q, pend_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;

  logic [7:0] clr_mask;
  logic [7:0] cand;
  logic [2:0] hi_idx;
  logic       accept;
  logic       load;

  always_comb begin
    accept   = valid_q & ack;
    clr_mask = accept ? (8'h01 << code_q) : '0;
    // cand excludes this edge's req, so a new strobe is presented one edge later
    cand     = pend_q & ~clr_mask;
    load     = ~valid_q | ack;

    // ascending scan: the last hit is the highest-numbered set bit
    hi_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (cand[i]) hi_idx = 3'(i);
    end

    pend_d  = cand | req;
    code_d  = code_q;
    valid_d = valid_q;
    if (load) begin
      valid_d = |cand;
      if (|cand) code_d = hi_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign code    = code_q;
  assign valid   = valid_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_pending_encoder8.sv
// Self-checking bench for pending_encoder8: directed vector table, hand-written
// corner sequences, and randomized traffic against an event-level reference.
module tb_pending_encoder8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  pending_encoder8 dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .ack     (ack),
    .code    (code),
    .valid   (valid),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a set of outstanding event indices plus the one being presented.
  bit       m_out[8];
  bit       m_valid;
  int       m_code;
  int       presented_count[8];

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_out[i] = 0;
      presented_count[i] = 0;
    end
    m_valid = 0;
    m_code  = 0;
  endfunction

  function automatic logic [7:0] model_pending();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_out[i];
    return v;
  endfunction

  function automatic void model_edge(input logic [7:0] r, input logic a);
    bit avail[8];
    int best;
    for (int i = 0; i < 8; i++) avail[i] = m_out[i];
    if (m_valid && a) avail[m_code] = 0;
    if (!m_valid || a) begin
      best = -1;
      for (int i = 7; i >= 0; i--) begin
        if (avail[i] && best < 0) best = i;
      end
      m_valid = (best >= 0);
      if (best >= 0) begin
        m_code = best;
        presented_count[best]++;
      end
    end
    for (int i = 0; i < 8; i++) m_out[i] = avail[i] | r[i];
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic ev, input logic [2:0] ec,
                           input logic [7:0] ep);
    chk({name, ".valid"}, {7'd0, valid}, {7'd0, ev});
    chk({name, ".pending"}, pending, ep);
    if (ev) chk({name, ".code"}, {5'd0, code}, {5'd0, ec});
  endtask

  task automatic chk_model(input string name);
    chk_state(name, m_valid, 3'(m_code), model_pending());
  endtask

  // Called at posedge+1; applies inputs for one cycle and samples after the edge.
  task automatic step(input logic [7:0] r, input logic a);
    req = r;
    ack = a;
    model_edge(r, a);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] req;
    logic       ack;
    logic       ev;
    logic [2:0] ec;
    logic [7:0] ep;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [7:0] r, input logic a, input logic ev,
                              input logic [2:0] ec, input logic [7:0] ep);
    vec_t v;
    v.req = r; v.ack = a; v.ev = ev; v.ec = ec; v.ep = ep;
    tbl.push_back(v);
  endfunction

  initial begin
    rst = 1'b1;
    req = '0;
    ack = 1'b0;
    model_reset();

    // single event
    add(8'h20, 0, 0, 3'd0, 8'h20);
    add(8'h00, 0, 1, 3'd5, 8'h20);
    add(8'h00, 1, 0, 3'd0, 8'h00);
    // priority and hold
    add(8'h05, 0, 0, 3'd0, 8'h05);
    add(8'h00, 0, 1, 3'd2, 8'h05);
    add(8'h80, 0, 1, 3'd2, 8'h85);
    add(8'h80, 0, 1, 3'd2, 8'h85);
    add(8'h80, 0, 1, 3'd2, 8'h85);
    add(8'h00, 1, 1, 3'd7, 8'h81);
    add(8'h00, 1, 1, 3'd0, 8'h01);
    add(8'h00, 1, 0, 3'd0, 8'h00);
    // drain with ack held high
    add(8'hFF, 0, 0, 3'd0, 8'hFF);
    add(8'h00, 1, 1, 3'd7, 8'hFF);
    add(8'h00, 1, 1, 3'd6, 8'h7F);
    add(8'h00, 1, 1, 3'd5, 8'h3F);
    add(8'h00, 1, 1, 3'd4, 8'h1F);
    add(8'h00, 1, 1, 3'd3, 8'h0F);
    add(8'h00, 1, 1, 3'd2, 8'h07);
    add(8'h00, 1, 1, 3'd1, 8'h03);
    add(8'h00, 1, 1, 3'd0, 8'h01);
    add(8'h00, 1, 0, 3'd0, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_state("post_reset", 0, 3'd0, 8'h00);

    for (int unsigned k = 0; k < tbl.size(); k++) begin
      step(tbl[k].req, tbl[k].ack);
      chk_state($sformatf("vec%0d", k), tbl[k].ev, tbl[k].ec, tbl[k].ep);
      chk_model($sformatf("vec%0d_model", k));
    end

    // asynchronous reset mid-handshake, with req asserted
    step(8'hFF, 0);
    step(8'h00, 0);
    chk_state("pre_rst", 1, 3'd7, 8'hFF);
    #2;
    rst = 1'b1;
    req = 8'hFF;
    #1;
    chk({"async_rst", ".code"}, {5'd0, code}, 8'h00);
    chk_state("async_rst", 0, 3'd0, 8'h00);
    @(posedge clk);
    #1;
    chk_state("rst_held", 0, 3'd0, 8'h00);
    rst = 1'b0;
    req = '0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step(8'h00, 0);
      chk_state($sformatf("idle%0d", i), 0, 3'd0, 8'h00);
    end

    // simultaneous set and clear of the presented bit
    step(8'h08, 0);
    step(8'h00, 0);
    chk_state("sc_present", 1, 3'd3, 8'h08);
    step(8'h08, 1);
    chk_state("sc_edge", 0, 3'd0, 8'h08);
    step(8'h00, 0);
    chk_state("sc_repres", 1, 3'd3, 8'h08);
    step(8'h00, 1);
    chk_state("sc_done", 0, 3'd0, 8'h00);

    // spurious ack while idle
    step(8'h00, 1);
    chk_state("spur_ack", 0, 3'd0, 8'h00);

    // duplicate request collapses to one event
    model_reset();
    for (int i = 0; i < 4; i++) step(8'h10, 0);
    chk_state("dup_hold", 1, 3'd4, 8'h10);
    step(8'h00, 1);
    chk_state("dup_acked", 0, 3'd0, 8'h00);
    step(8'h00, 0);
    step(8'h00, 0);
    chk_state("dup_quiet", 0, 3'd0, 8'h00);
    chk("dup_presentations", 8'(presented_count[4]), 8'd1);

    // randomized traffic vs reference
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      logic a;
      r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      a = 1'($urandom_range(0, 1));
      step(r, a);
      chk_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pending_encoder8.md
# pending_encoder8

Registered 8-to-3 priority encoder with sticky request capture and a valid/ack handshake. It is the encoding counterpart of the 3-to-8 decoder. Eight single-cycle request lines are latched into a pending register. The block presents the highest-numbered pending request as a 3-bit code and holds it stable until the consumer acknowledges it. It sits between event sources (flag/exception strobes around the ALU) and any consumer that takes one encoded event at a time.

## Interface
Parameters: none (width fixed at 8 requests / 3-bit code).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  8  request strobes; bit i set for ≥1 cycle marks event i pending
- ack  input  1  consumer accepts current code; meaningful only while valid=1
- code  output  3  index of presented request, registered
- valid  output  1  code holds a pending request, registered
- pending  output  8  current pending register contents

## Operation
- State: pend[7:0], out_code[2:0], out_valid.
- clr_mask = onehot(code) when valid & ack, else 8'h00.
- Pend update each edge: pend <= (pend & ~clr_mask) | req.
  - If req[i] and clr_mask[i] occur in the same cycle, set wins. The bit stays pending as a new event.
- Output register loads only when idle or accepting (valid=0, or valid=1 & ack=1):
  - cand = pend & ~clr_mask (pend before this edge's req merge).
  - If cand ≠ 0: valid <= 1, code <= index of highest set bit of cand (bit 7 highest priority).
  - If cand = 0: valid <= 0. code holds its last value (don't-care).
- While valid=1 & ack=0: code and valid are held. Higher-priority requests arriving meanwhile only set pend.
- The presented bit stays set in pend until its ack. It is never presented twice for one event unless re-requested.
- ack while valid=0: ignored, no state change.
- Repeated req on an already pending bit: absorbed (one event).

## Timing
- Reset (async assert): pend=8'h00, code=3'b000, valid=0, pending=8'h00. Takes effect immediately and overrides any edge in progress. First update occurs on the first rising edge after deassert.
- Latency, idle block: req[i] high during cycle N → pend[i]=1 after edge N → valid=1, code=i after edge N+1 (2 edges).
- Ack handshake: valid & ack sampled on edge E → bit cleared and next code (or valid=0) visible after E.
  - With ack held high continuously, one code is retired per cycle.
- Back-to-back: all 8 bits pending with ack held high gives codes 7,6,…,0 on 8 consecutive cycles, then valid=0.
- Reset mid-handshake (valid=1, ack pending): all state is dropped. Events present before reset are lost.

## Test plan
- Reset: assert rst with req=8'hFF → pending=00, valid=0, code=000 immediately. After release with req=0, state stays 0 for 5 cycles.
- Single event: req=8'h20 for one cycle → after 2 edges valid=1, code=101, pending=8'h20. ack one cycle → pending=00, valid=0.
- Priority and hold: req=8'h05 one cycle. After valid (code=010), req=8'h80 with ack=0 for 3 cycles → code stays 010. ack → code=111. ack → code=000. ack → valid=0.
- Drain: req=8'hFF one cycle, then ack held high → codes 7..0 on consecutive cycles, then valid=0, pending=00.
- Simultaneous set/clear: presenting code=011, apply ack=1 and req=8'h08 in the same cycle → pending[3] stays 1, code=011 re-presented next cycle, valid=1.
- Spurious ack and duplicate req: ack=1 with valid=0 → no change. req[4] high 4 cycles → exactly one presentation of code=100.
